// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   WIDTH     : operand width, fixed at 32 to match adder_32b
//   CNT_W     : iteration counter width, holds 0..WIDTH
//   LAST_ITER : counter value of the final (32nd) iteration
package mult_pkg;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LAST_ITER = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_32b.sv
// 32-bit ripple-style adder used as the multiplier's partial-sum datapath.
// Ports:
//   a, b : addends (WIDTH bits)
//   cin  : carry in
//   sum  : WIDTH-bit sum
//   cout : carry out
module adder_32b
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/mult_32b_seq.sv
// Unsigned 32x32->64 sequential shift-add multiplier, one partial product
// per clock, with valid/ready handshakes on both sides.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   mcand, mplier       : operands, captured on accept
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   product             : 64-bit result, stable while out_valid is high
// Build option:
//   MULT_EARLY_TERM_EN  : when defined, finish as soon as the remaining
//                         multiplier bits are all zero (shorter latency,
//                         identical product).
module mult_32b_seq
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    state_t               state;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   next_acc;

`ifdef MULT_EARLY_TERM_EN
    logic [WIDTH-1:0]     mq;
    logic [CNT_W:0]       shift_amt;
    logic [2*WIDTH-1:0]   early_acc;
`endif

    // Add the multiplicand when the current multiplier bit (lo[0]) is set.
    always_comb begin
        addend = lo[0] ? mc : '0;
    end

    adder_32b u_adder (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // 65-bit right shift of {cout, sum, lo}: the carry lands in hi[31]
    // and the consumed multiplier bit drops off the bottom of lo.
    always_comb begin
        next_acc = {cout, sum, lo[WIDTH-1:1]};
    end

`ifdef MULT_EARLY_TERM_EN
    // Once no multiplier bits remain, the outstanding iterations would only
    // add zero and shift, so collapse them into one shift by (32 - cnt).
    always_comb begin
        shift_amt = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
        early_acc = {hi, lo} >> shift_amt;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mc        <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
`ifdef MULT_EARLY_TERM_EN
            mq        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mc       <= mcand;
                        lo       <= mplier;
                        hi       <= '0;
                        cnt      <= '0;
`ifdef MULT_EARLY_TERM_EN
                        mq       <= mplier;
`endif
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
`ifdef MULT_EARLY_TERM_EN
                    if (mq == '0) begin
                        {hi, lo}  <= early_acc;
                        product   <= early_acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else
`endif
                    begin
                        {hi, lo} <= next_acc;
                        cnt      <= cnt + CNT_W'(1);
`ifdef MULT_EARLY_TERM_EN
                        mq       <= mq >> 1;
`endif
                        if (cnt == CNT_W'(LAST_ITER)) begin
                            product   <= next_acc;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
